// File: rtl/basketball_pkg.sv
// Shared constants for the basketball scoreboard: team/point codes, FSM states
// and bit positions of the debounced key vector.
package basketball_pkg;

  localparam logic       TEAM_YELLOW = 1'b0;
  localparam logic       TEAM_RED    = 1'b1;

  localparam logic [1:0] PTS_1 = 2'd1;
  localparam logic [1:0] PTS_2 = 2'd2;
  localparam logic [1:0] PTS_3 = 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam int KDB_K1  = 0;
  localparam int KDB_K2  = 1;
  localparam int KDB_K3  = 2;
  localparam int KDB_YEL = 3;
  localparam int KDB_RED = 4;

  // Point value of a one-hot point-key vector; callers guarantee exactly one bit set.
  function automatic logic [1:0] pts_of(input logic [2:0] pk);
    logic [1:0] pts;
    pts = PTS_1;
    case (pk)
      3'b010:  pts = PTS_2;
      3'b100:  pts = PTS_3;
      default: pts = PTS_1;
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser followed by a stability counter: the debounced level only
// follows the input after DEBOUNCE_CYC consecutive cycles of disagreement.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk_in,
  input  logic rst,
  input  logic raw,
  output logic db
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic             s1_q, s2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        db_d  = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/score_key_conditioner.sv
// Debounces the five scoreboard buttons and converts each point-key press into a
// single scoring event or an ambiguity error pulse.
module score_key_conditioner
  import basketball_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       en_score,
  input  logic       key_1,
  input  logic       key_2,
  input  logic       key_3,
  input  logic       key_yellow,
  input  logic       key_red,
  output logic       score_vld,
  output logic       score_team,
  output logic [1:0] score_pts,
  output logic       score_err,
  output logic [4:0] key_db
);

  logic [4:0] raw_w;
  logic [4:0] db_w;

  assign raw_w[KDB_K1]  = key_1;
  assign raw_w[KDB_K2]  = key_2;
  assign raw_w[KDB_K3]  = key_3;
  assign raw_w[KDB_YEL] = key_yellow;
  assign raw_w[KDB_RED] = key_red;

  for (genvar g = 0; g < 5; g++) begin : g_db
    key_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_db (
      .clk_in(clk_in),
      .rst   (rst),
      .raw   (raw_w[g]),
      .db    (db_w[g])
    );
  end

  logic [2:0] pk;
  logic [1:0] tk;
  logic       rise;
  logic       pk_onehot;
  logic       tk_onehot;

  logic [2:0] pk_prev_q;
  logic [0:0] state_q, state_d;
  logic       vld_q, vld_d;
  logic       err_q, err_d;
  logic       team_q, team_d;
  logic [1:0] pts_q, pts_d;

  assign pk        = db_w[KDB_K3:KDB_K1];
  assign tk        = db_w[KDB_RED:KDB_YEL];
  assign rise      = |(pk & ~pk_prev_q);
  assign pk_onehot = (pk == 3'b001) || (pk == 3'b010) || (pk == 3'b100);
  assign tk_onehot = (tk == 2'b01) || (tk == 2'b10);

  // A press is judged once, in the cycle its rise appears; HOLD waits for full release.
  always_comb begin
    state_d = state_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    team_d  = team_q;
    pts_d   = pts_q;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HOLD;
          if (en_score) begin
            if (pk_onehot && tk_onehot) begin
              vld_d  = 1'b1;
              pts_d  = pts_of(pk);
              team_d = tk[KDB_RED - KDB_YEL] ? TEAM_RED : TEAM_YELLOW;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      default: begin
        if (pk == 3'b000) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      pk_prev_q <= '0;
      state_q   <= ST_IDLE;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
      team_q    <= TEAM_YELLOW;
      pts_q     <= 2'd0;
    end else begin
      pk_prev_q <= pk;
      state_q   <= state_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      team_q    <= team_d;
      pts_q     <= pts_d;
    end
  end

  assign score_vld  = vld_q;
  assign score_err  = err_q;
  assign score_team = team_q;
  assign score_pts  = pts_q;
  assign key_db     = db_w;

endmodule

// File: tb/tb_score_key_conditioner.sv
// Scoreboard bench for score_key_conditioner with a short debounce window.
module tb_score_key_conditioner;

  localparam int DC  = 8;
  localparam int LAT = DC + 3;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       en_score = 1'b0;
  logic       key_1 = 1'b0, key_2 = 1'b0, key_3 = 1'b0;
  logic       key_yellow = 1'b0, key_red = 1'b0;
  logic       score_vld, score_team, score_err;
  logic [1:0] score_pts;
  logic [4:0] key_db;

  always #10 clk_in = ~clk_in;

  score_key_conditioner #(
    .DEBOUNCE_CYC(DC)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en_score  (en_score),
    .key_1     (key_1),
    .key_2     (key_2),
    .key_3     (key_3),
    .key_yellow(key_yellow),
    .key_red   (key_red),
    .score_vld (score_vld),
    .score_team(score_team),
    .score_pts (score_pts),
    .score_err (score_err),
    .key_db    (key_db)
  );

  typedef struct {
    int         cyc;
    bit         err;
    bit         team;
    logic [1:0] pts;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic push_exp(input bit err, input bit team, input logic [1:0] pts);
    exp_t x;
    x.cyc  = cyc + LAT;
    x.err  = err;
    x.team = team;
    x.pts  = pts;
    sb.push_back(x);
  endtask

  always @(negedge clk_in) begin
    if (score_vld || score_err) begin
      check_eq("vld_err_exclusive", 32'(score_vld & score_err), 0);
      if (sb.size() == 0) begin
        check_eq("unexpected_pulse", 32'({score_vld, score_err}), 0);
      end else begin
        e = sb.pop_front();
        check_eq("evt_cycle", cyc, e.cyc);
        check_eq("evt_is_err", 32'(score_err), 32'(e.err));
        if (!e.err) begin
          check_eq("evt_team", 32'(score_team), 32'(e.team));
          check_eq("evt_pts", 32'(score_pts), 32'(e.pts));
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_vld"}, 32'(score_vld), 0);
    check_eq({tag, "_err"}, 32'(score_err), 0);
    check_eq({tag, "_team"}, 32'(score_team), 0);
    check_eq({tag, "_pts"}, 32'(score_pts), 0);
    check_eq({tag, "_keydb"}, 32'(key_db), 0);
  endtask

  initial begin
    // Power-on reset
    wait_cyc(3);
    check_all_zero("reset");
    rst = 1'b0;
    en_score = 1'b1;
    wait_cyc(5);

    // 1: yellow team, single +1 press held for 150 cycles
    key_yellow = 1'b1;
    wait_cyc(20);
    key_1 = 1'b1;
    push_exp(1'b0, 1'b0, 2'd1);
    wait_cyc(30);
    check_eq("t1_keydb", 32'(key_db), 32'b01001);
    wait_cyc(120);
    check_eq("t1_hold_pts", 32'(score_pts), 1);
    key_1 = 1'b0;
    key_yellow = 1'b0;
    wait_cyc(20);

    // 2: red team, bouncing +3 key settles high
    key_red = 1'b1;
    wait_cyc(20);
    for (int i = 0; i < 10; i++) begin
      key_3 = ~key_3;
      wait_cyc(3);
    end
    key_3 = 1'b1;
    push_exp(1'b0, 1'b1, 2'd3);
    wait_cyc(40);
    key_3 = 1'b0;
    wait_cyc(20);

    // 3: ambiguous team selection -> error, then no team key -> error
    key_yellow = 1'b1;
    wait_cyc(20);
    key_2 = 1'b1;
    push_exp(1'b1, 1'b0, 2'd0);
    wait_cyc(20);
    check_eq("t3_keydb", 32'(key_db), 32'b11010);
    key_2 = 1'b0;
    wait_cyc(20);
    key_yellow = 1'b0;
    key_red = 1'b0;
    wait_cyc(20);
    key_2 = 1'b1;
    push_exp(1'b1, 1'b0, 2'd0);
    wait_cyc(20);
    check_eq("t3_hold_pts", 32'(score_pts), 3);
    key_2 = 1'b0;
    wait_cyc(20);

    // 4: scoring disabled consumes press; re-enabled press scores
    en_score = 1'b0;
    key_red = 1'b1;
    key_3 = 1'b1;
    wait_cyc(25);
    key_3 = 1'b0;
    wait_cyc(20);
    en_score = 1'b1;
    key_2 = 1'b1;
    push_exp(1'b0, 1'b1, 2'd2);
    wait_cyc(20);
    key_2 = 1'b0;
    key_red = 1'b0;
    wait_cyc(20);
    check_eq("t4_hold_team", 32'(score_team), 1);

    // 5: second point key added while first held is ignored
    key_yellow = 1'b1;
    wait_cyc(20);
    key_1 = 1'b1;
    push_exp(1'b0, 1'b0, 2'd1);
    wait_cyc(20);
    key_2 = 1'b1;
    wait_cyc(25);
    key_1 = 1'b0;
    key_2 = 1'b0;
    wait_cyc(20);
    key_2 = 1'b1;
    push_exp(1'b0, 1'b0, 2'd2);
    wait_cyc(20);
    key_2 = 1'b0;
    wait_cyc(20);

    // 6: reset in the middle of a key_3 debounce with yellow held
    key_3 = 1'b1;
    wait_cyc(4);
    rst = 1'b1;
    wait_cyc(3);
    check_all_zero("t6_reset");
    rst = 1'b0;
    push_exp(1'b0, 1'b0, 2'd3);
    wait_cyc(25);
    key_3 = 1'b0;
    key_yellow = 1'b0;
    wait_cyc(30);

    check_eq("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
